// File: rtl/game_pkg.sv
// Shared game types and geometry defaults for the obstacle game.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        WON  = 2'd3
    } judge_state_t;

    localparam int PLAYER_X  = 100;
    localparam int PLAYER_W  = 16;
    localparam int OBS_W     = 16;
    localparam int OBS_H     = 24;
    localparam int WIN_COUNT = 20;

endpackage

// File: rtl/obs_overlap.sv
// Per-slot geometry test: overlap with player, fully passed, respawned right.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the slot inputs.
module obs_overlap #(
    parameter int X_W      = 10,
    parameter int PLAYER_X = 100,
    parameter int PLAYER_W = 16,
    parameter int OBS_W    = 16,
    parameter int OBS_H    = 24
) (
    input  logic [X_W-1:0] x,
    input  logic           valid,
    input  logic [X_W-1:0] distance,
    output logic           overlap,
    output logic           passed_cond,
    output logic           respawn_cond
);

    // One extra bit of headroom so x + OBS_W can never wrap.
    localparam logic [X_W:0] PX_BEG = (X_W+1)'(PLAYER_X);
    localparam logic [X_W:0] PX_END = (X_W+1)'(PLAYER_X + PLAYER_W);
    localparam logic [X_W:0] OW     = (X_W+1)'(OBS_W);
    localparam logic [X_W:0] OH     = (X_W+1)'(OBS_H);

    logic [X_W:0] x_ext;
    logic [X_W:0] x_end;
    logic [X_W:0] dist_ext;

    assign x_ext    = {1'b0, x};
    assign x_end    = x_ext + OW;
    assign dist_ext = {1'b0, distance};

    assign overlap      = valid && (x_ext < PX_END) && (x_end > PX_BEG) && (dist_ext < OH);
    assign passed_cond  = valid && (x_end <= PX_BEG);
    assign respawn_cond = (x_ext >= PX_END);

endmodule

// File: rtl/collision_judge.sv
// Per-tick collision/score judge driving playerDeath and win for the game FSM.
// Latency: one cycle from a sampled game_tick to updated outputs.
// Backpressure: none; evaluates every game_tick while in RUN, holds otherwise.
module collision_judge #(
    parameter int NUM_OBS       = 4,
    parameter int X_W           = 10,
    parameter int PLAYER_X      = game_pkg::PLAYER_X,
    parameter int PLAYER_W      = game_pkg::PLAYER_W,
    parameter int OBS_W         = game_pkg::OBS_W,
    parameter int OBS_H         = game_pkg::OBS_H,
    parameter int DEATH_CONFIRM = 2,
    parameter int WIN_COUNT     = game_pkg::WIN_COUNT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   game_tick,
    input  logic                   play_en,
    input  logic [X_W-1:0]         distance,
    input  logic [NUM_OBS*X_W-1:0] obs_x,
    input  logic [NUM_OBS-1:0]     obs_valid,
    output logic                   playerDeath,
    output logic                   win,
    output logic [7:0]             score,
    output logic [NUM_OBS-1:0]     hit_flags
);

    import game_pkg::*;

    localparam int HC_W  = $clog2(DEATH_CONFIRM + 1);
    localparam int CNT_W = $clog2(NUM_OBS + 1);

    judge_state_t state, state_next;

    logic [HC_W-1:0]    hit_cnt, hit_next;
    logic [NUM_OBS-1:0] ov, pc, rc;
    logic [NUM_OBS-1:0] passed, passed_next;
    logic [NUM_OBS-1:0] hist, hist_next;
    logic [NUM_OBS-1:0] clr;
    logic [CNT_W-1:0]   clr_cnt;
    logic [8:0]         sum_ext;
    logic [7:0]         score_next;
    logic               eval, any_ov, death_hit, win_hit;
    int                 hit_inc;

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
        obs_overlap #(
            .X_W      (X_W),
            .PLAYER_X (PLAYER_X),
            .PLAYER_W (PLAYER_W),
            .OBS_W    (OBS_W),
            .OBS_H    (OBS_H)
        ) u_ovl (
            .x            (obs_x[g*X_W +: X_W]),
            .valid        (obs_valid[g]),
            .distance     (distance),
            .overlap      (ov[g]),
            .passed_cond  (pc[g]),
            .respawn_cond (rc[g])
        );
    end

    assign eval        = (state == RUN) && play_en && game_tick;
    assign playerDeath = (state == DEAD);
    assign win         = (state == WON);

    // Tick evaluation: hit counter, per-slot passed/history flags and score sum.
    always_comb begin
        any_ov      = |ov;
        hit_inc     = int'(hit_cnt) + 1;
        death_hit   = any_ov && (hit_inc >= DEATH_CONFIRM);
        hit_next    = '0;
        clr_cnt     = '0;
        passed_next = passed;
        hist_next   = hist;
        clr         = '0;
        if (any_ov) begin
            hit_next = death_hit ? HC_W'(DEATH_CONFIRM) : HC_W'(hit_inc);
        end
        for (int i = 0; i < NUM_OBS; i++) begin
            // A pass only scores if the slot never overlapped since it last reset.
            clr[i]  = pc[i] && !passed[i] && !hist[i];
            clr_cnt = clr_cnt + CNT_W'(clr[i]);
            if (rc[i] || !obs_valid[i]) begin
                passed_next[i] = 1'b0;
                hist_next[i]   = 1'b0;
            end else begin
                if (pc[i]) passed_next[i] = 1'b1;
                if (ov[i]) hist_next[i]   = 1'b1;
            end
        end
        sum_ext    = {1'b0, score} + 9'(clr_cnt);
        win_hit    = int'(sum_ext) >= WIN_COUNT;
        score_next = win_hit ? 8'(WIN_COUNT) : sum_ext[7:0];
    end

    // Next-state logic; death takes priority over win on the same tick.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (play_en) state_next = RUN;
            RUN: begin
                if (!play_en)             state_next = IDLE;
                else if (eval && death_hit) state_next = DEAD;
                else if (eval && win_hit)   state_next = WON;
            end
            DEAD, WON: if (!play_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath registers: cleared in IDLE or when play stops, updated on evaluated ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt   <= '0;
            passed    <= '0;
            hist      <= '0;
            score     <= '0;
            hit_flags <= '0;
        end else if (state == IDLE || !play_en) begin
            hit_cnt   <= '0;
            passed    <= '0;
            hist      <= '0;
            score     <= '0;
            hit_flags <= '0;
        end else if (eval) begin
            hit_cnt   <= hit_next;
            passed    <= passed_next;
            hist      <= hist_next;
            score     <= score_next;
            hit_flags <= ov;
        end
    end

endmodule

// File: tb/tb_collision_judge.sv
// Directed self-checking bench for collision_judge.
// Latency: checks one cycle after each tick.
// Backpressure: not applicable.
module tb_collision_judge;
    import game_pkg::*;

    localparam int NOBS = 4;
    localparam int XW   = 10;

    logic              clk;
    logic              reset;
    logic              game_tick;
    logic              play_en;
    logic [XW-1:0]     distance;
    logic [NOBS*XW-1:0] obs_x;
    logic [NOBS-1:0]   obs_valid;
    logic              playerDeath;
    logic              win;
    logic [7:0]        score;
    logic [NOBS-1:0]   hit_flags;

    int total = 0;
    int bad   = 0;

    collision_judge dut (
        .clk         (clk),
        .reset       (reset),
        .game_tick   (game_tick),
        .play_en     (play_en),
        .distance    (distance),
        .obs_x       (obs_x),
        .obs_valid   (obs_valid),
        .playerDeath (playerDeath),
        .win         (win),
        .score       (score),
        .hit_flags   (hit_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle, optionally with a tick; returns 1ns after the edge.
    task automatic cyc(input logic tk);
        game_tick = tk;
        @(posedge clk);
        #1;
        game_tick = 1'b0;
    endtask

    task automatic set_slot(input int i, input int x, input logic v);
        obs_x[i*XW +: XW] = 10'(x);
        obs_valid[i]      = v;
    endtask

    // Respawn every slot, then bring n slots to x=84 (just cleared the player).
    task automatic clear_round(input int n);
        for (int i = 0; i < NOBS; i++) set_slot(i, 600, 1'b1);
        cyc(1'b1);
        for (int i = 0; i < n; i++) set_slot(i, 84, 1'b1);
        cyc(1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        game_tick = 1'b0;
        play_en   = 1'b0;
        distance  = '0;
        obs_x     = '0;
        obs_valid = '0;
        #1;
        chk("rst_score", 32'(score), 0);
        chk("rst_death", 32'(playerDeath), 0);
        chk("rst_win", 32'(win), 0);
        chk("rst_hits", 32'(hit_flags), 0);
        @(negedge clk);
        reset = 1'b0;

        // Running with no obstacles.
        play_en = 1'b1;
        cyc(1'b0);
        repeat (3) cyc(1'b1);
        chk("empty_state", 32'(dut.state), 32'(RUN));
        chk("empty_score", 32'(score), 0);
        chk("empty_death", 32'(playerDeath), 0);
        chk("empty_win", 32'(win), 0);

        // Two consecutive overlapping ticks confirm death.
        set_slot(0, 110, 1'b1);
        distance = 10'd0;
        cyc(1'b1);
        chk("hit1_flags", 32'(hit_flags), 1);
        chk("hit1_death", 32'(playerDeath), 0);
        cyc(1'b1);
        chk("hit2_death", 32'(playerDeath), 1);
        play_en = 1'b0;
        cyc(1'b0);
        chk("dead_idle_death", 32'(playerDeath), 0);
        chk("dead_idle_flags", 32'(hit_flags), 0);

        // Jumping over a slot scores; a slot that hit does not.
        play_en = 1'b1;
        cyc(1'b0);
        distance = 10'd30;
        set_slot(0, 110, 1'b1); cyc(1'b1);
        chk("jump_flags", 32'(hit_flags), 0);
        set_slot(0, 97, 1'b1);  cyc(1'b1);
        chk("jump97_score", 32'(score), 0);
        set_slot(0, 84, 1'b1);  cyc(1'b1);
        chk("pass1_score", 32'(score), 1);
        set_slot(0, 60, 1'b1);  cyc(1'b1);
        chk("pass_hold", 32'(score), 1);
        set_slot(0, 600, 1'b1); cyc(1'b1);
        set_slot(0, 84, 1'b1);  cyc(1'b1);
        chk("pass2_score", 32'(score), 2);
        set_slot(0, 600, 1'b1); cyc(1'b1);
        distance = 10'd0;
        set_slot(0, 110, 1'b1); cyc(1'b1);
        chk("dirty_hit", 32'(hit_flags), 1);
        set_slot(0, 84, 1'b1);  cyc(1'b1);
        chk("dirty_score", 32'(score), 2);
        chk("dirty_death", 32'(playerDeath), 0);

        // Two slots clearing on one tick add two.
        distance = 10'd30;
        set_slot(0, 600, 1'b1); set_slot(1, 600, 1'b1); cyc(1'b1);
        set_slot(0, 84, 1'b1);  set_slot(1, 84, 1'b1);  cyc(1'b1);
        chk("dual_score", 32'(score), 4);
        repeat (3) clear_round(4);
        clear_round(3);
        chk("pre_win_score", 32'(score), 19);
        chk("pre_win_win", 32'(win), 0);
        clear_round(1);
        chk("win_flag", 32'(win), 1);
        chk("win_score", 32'(score), 20);
        clear_round(2);
        chk("won_hold", 32'(score), 20);
        play_en = 1'b0;
        cyc(1'b0);
        chk("won_idle_win", 32'(win), 0);
        chk("won_idle_score", 32'(score), 0);

        // Death and win on the same tick: death wins, score still updates.
        play_en = 1'b1;
        cyc(1'b0);
        clear_round(4); clear_round(4); clear_round(4); clear_round(4); clear_round(3);
        chk("sim_pre_score", 32'(score), 19);
        for (int i = 0; i < NOBS; i++) set_slot(i, 600, 1'b1);
        cyc(1'b1);
        distance = 10'd0;
        set_slot(0, 110, 1'b1); cyc(1'b1);
        set_slot(1, 84, 1'b1);  cyc(1'b1);
        chk("sim_death", 32'(playerDeath), 1);
        chk("sim_win", 32'(win), 0);
        chk("sim_score", 32'(score), 20);
        play_en = 1'b0;
        cyc(1'b0);
        chk("sim_idle_score", 32'(score), 0);
        chk("sim_idle_death", 32'(playerDeath), 0);

        // Tick coinciding with play_en rising is ignored; then async reset mid-run.
        distance = 10'd30;
        for (int i = 0; i < NOBS; i++) set_slot(i, 600, 1'b0);
        set_slot(0, 84, 1'b1);
        play_en = 1'b1;
        cyc(1'b1);
        chk("entry_tick_ignored", 32'(score), 0);
        cyc(1'b1);
        chk("first_run_tick", 32'(score), 1);
        clear_round(4);
        clear_round(2);
        chk("mid_score", 32'(score), 7);
        #2;
        reset = 1'b1;
        #1;
        chk("async_score", 32'(score), 0);
        chk("async_death", 32'(playerDeath), 0);
        chk("async_win", 32'(win), 0);
        chk("async_flags", 32'(hit_flags), 0);
        @(negedge clk);
        reset   = 1'b0;
        play_en = 1'b0;
        cyc(1'b0);
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
